// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select sequencer and round-robin arbiter for a 4-input inverting NEM-relay mux.
// At most one select line is closed; release (T_OFF) and settle (T_ON) times are enforced in cycles.
module nem_ohmux_sel_ctrl #(
   parameter int T_ON  = 5,
   parameter int T_OFF = 3,
   parameter int CW    = 4
) (
   input  logic       CP,
   input  logic       RST,
   input  logic [3:0] REQ,
   output logic       S0,
   output logic       S1,
   output logic       S2,
   output logic       S3,
   output logic [3:0] GNT,
   output logic [1:0] OWNER,
   output logic       BUSY
);

   typedef enum logic [1:0] {IDLE, MAKE, HOLD, BREAK} state_t;

   localparam logic [CW-1:0] ON_LOAD  = CW'(T_ON - 1);
   localparam logic [CW-1:0] OFF_LOAD = CW'(T_OFF - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [1:0]    rr;
   logic [1:0]    rr_nxt;
   logic [1:0]    owner_nxt;
   logic [1:0]    winner;
   logic          launch;
   logic [3:0]    sel;
   logic [3:0]    sel_nxt;
   logic [3:0]    gnt_nxt;
   logic          busy_nxt;

   // Lowest offset from the pointer wins: the reverse walk lets it overwrite last.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      winner    = rr_pick(REQ, rr);
      state_nxt = state;
      cnt_nxt   = cnt;
      owner_nxt = OWNER;
      rr_nxt    = rr;
      launch    = 1'b0;
      case (state)
         IDLE: launch = |REQ;
         MAKE: begin
            if (!REQ[OWNER]) begin
               state_nxt = BREAK;
               cnt_nxt   = OFF_LOAD;
            end else if (cnt == '0) begin
               state_nxt = HOLD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         HOLD: begin
            if (!REQ[OWNER]) begin
               state_nxt = BREAK;
               cnt_nxt   = OFF_LOAD;
            end
         end
         BREAK: begin
            if (cnt == '0) begin
               if (|REQ) launch = 1'b1;
               else      state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = BREAK;
            cnt_nxt   = OFF_LOAD;
         end
      endcase

      if (launch) begin
         state_nxt = MAKE;
         cnt_nxt   = ON_LOAD;
         owner_nxt = winner;
         rr_nxt    = winner + 2'd1;
      end

      // Outputs are precomputed from the next state so every pin comes straight off a flop.
      sel_nxt  = (state_nxt == MAKE || state_nxt == HOLD) ? (4'b0001 << owner_nxt) : 4'b0000;
      gnt_nxt  = (state_nxt == HOLD) ? (4'b0001 << owner_nxt) : 4'b0000;
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         state <= BREAK;
         cnt   <= OFF_LOAD;
         rr    <= 2'd0;
         OWNER <= 2'd0;
         sel   <= 4'b0000;
         GNT   <= 4'b0000;
         BUSY  <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rr    <= rr_nxt;
         OWNER <= owner_nxt;
         sel   <= sel_nxt;
         GNT   <= gnt_nxt;
         BUSY  <= busy_nxt;
      end
   end

   assign {S3, S2, S1, S0} = sel;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Bench for nem_ohmux_sel_ctrl: directed scenarios then random REQ/RST traffic,
// checked every cycle against a timestamp-based reference model.
module tb_nem_ohmux_sel_ctrl;

   localparam int T_ON  = 5;
   localparam int T_OFF = 3;

   logic       CP = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] REQ = 4'b0000;
   logic       S0, S1, S2, S3;
   logic [3:0] GNT;
   logic [1:0] OWNER;
   logic       BUSY;
   logic [3:0] s_vec;

   assign s_vec = {S3, S2, S1, S0};

   always #5 CP = ~CP;

   nem_ohmux_sel_ctrl #(.T_ON(T_ON), .T_OFF(T_OFF), .CW(4)) dut (
      .CP(CP), .RST(RST), .REQ(REQ),
      .S0(S0), .S1(S1), .S2(S2), .S3(S3),
      .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference: path connected to m_conn since edge m_rise; lines last opened at edge m_fall.
   int         c = 0;
   int         m_conn = -1;
   int         m_rise = 0;
   int         m_fall = 0;
   int         m_owner = 0;
   int         m_rr = 0;
   logic [3:0] m_s = 4'b0000;
   logic [3:0] m_gnt = 4'b0000;
   logic       m_busy = 1'b1;

   logic       log_on = 1'b0;
   logic [3:0] gnt_prev = 4'b0000;
   int         glog[$];
   int         exp_order[5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst_v, input logic [3:0] req_v);
      int w;
      c++;
      if (rst_v) begin
         m_conn = -1; m_fall = c; m_owner = 0; m_rr = 0;
      end else if (m_conn >= 0) begin
         if (!req_v[m_conn]) begin
            m_conn = -1; m_fall = c;
         end
      end else if (req_v != 4'b0000 && (c - m_fall) >= T_OFF) begin
         w = -1;
         for (int k = 0; k < 4; k++)
            if (w < 0 && req_v[(m_rr + k) % 4]) w = (m_rr + k) % 4;
         m_conn = w; m_rise = c; m_owner = w; m_rr = (w + 1) % 4;
      end
      m_s    = (m_conn >= 0) ? 4'(1 << m_conn) : 4'b0000;
      m_gnt  = (m_conn >= 0 && (c - m_rise) >= T_ON) ? m_s : 4'b0000;
      m_busy = (m_conn >= 0) || ((c - m_fall) < T_OFF);
   endtask

   task automatic cyc(input logic rst_v, input logic [3:0] req_v);
      RST = rst_v;
      REQ = req_v;
      @(posedge CP);
      model_edge(rst_v, req_v);
      #1;
      chk("s_lines", 8'(s_vec), 8'(m_s));
      chk("gnt", 8'(GNT), 8'(m_gnt));
      chk("owner", 8'(OWNER), 8'(m_owner));
      chk("busy", 8'(BUSY), 8'(m_busy));
      chk("s_at_most_one", 8'($countones(s_vec) <= 1), 8'd1);
      chk("gnt_zero_or_s", 8'((GNT == 4'b0000) || (GNT == s_vec)), 8'd1);
      if (log_on && GNT != 4'b0000 && gnt_prev == 4'b0000)
         for (int i = 0; i < 4; i++) if (GNT[i]) glog.push_back(i);
      gnt_prev = GNT;
   endtask

   initial begin
      logic [3:0] r;
      logic       rs;

      // Reset then release with no requests: three busy release cycles, then idle.
      cyc(1'b1, 4'b0000);
      cyc(1'b1, 4'b0000);
      repeat (6) cyc(1'b0, 4'b0000);

      // Single requester 2: settle, hold, release.
      repeat (10) cyc(1'b0, 4'b0100);
      repeat (6) cyc(1'b0, 4'b0000);

      // All requesting, each owner drops two cycles after its grant.
      cyc(1'b1, 4'b0000);
      cyc(1'b1, 4'b0000);
      log_on = 1'b1;
      glog.delete();
      for (int n = 0; n < 60; n++) begin
         r = 4'b1111;
         if (m_conn >= 0 && c == m_rise + T_ON + 1) r[m_conn] = 1'b0;
         cyc(1'b0, r);
      end
      log_on = 1'b0;
      chk("grant_count", 8'(glog.size() >= 5), 8'd1);
      for (int i = 0; i < 5; i++)
         chk("grant_order", (i < glog.size()) ? 8'(glog[i]) : 8'hff, 8'(exp_order[i]));
      repeat (6) cyc(1'b0, 4'b0000);

      // Request withdrawn during settle: no grant, full release follows.
      repeat (2) cyc(1'b0, 4'b0001);
      repeat (6) cyc(1'b0, 4'b0000);

      // Reset while holding input 3, request kept high through it.
      repeat (9) cyc(1'b0, 4'b1000);
      cyc(1'b1, 4'b1000);
      repeat (12) cyc(1'b0, 4'b1000);
      repeat (2) cyc(1'b0, 4'b1100);
      cyc(1'b0, 4'b0100);
      repeat (10) cyc(1'b0, 4'b0100);
      cyc(1'b0, 4'b0000);
      repeat (4) cyc(1'b0, 4'b0100);

      // Random traffic with occasional reset.
      r = 4'b0000;
      for (int n = 0; n < 500; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(11) == 0) r[b] = ~r[b];
         rs = ($urandom_range(149) == 0);
         cyc(rs, r);
      end
      repeat (8) cyc(1'b0, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
